// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, rcon table, key-schedule FSM encoding
// and GF(2^8) helpers used by the S-box.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [3:0] rk_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } key_state_e;

    function automatic logic [7:0] rcon_lut(input rk_idx_t rnd);
        logic [7:0] r;
        unique case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 = product of a^(2^k), k=1..7; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] p;
        s = a;
        p = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: RotWord, SubWord, rcon XOR and word chain.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    localparam int NUM_LANES = 4;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t, n0, n1, n2, n3;
    logic [NUM_LANES-1:0][7:0] rot_w;
    logic [NUM_LANES-1:0][7:0] sub_w;

    assign {w0, w1, w2, w3} = prev_key;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .data_i (rot_w[g]),
            .data_o (sub_w[g])
        );
    end

    assign t  = sub_w ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    logic [7:0] inv;

    assign inv    = gf_inv(data_i);
    assign data_o = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry
// store, with a registered indexed read port usable while expansion runs.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR              = 10,
    parameter bit ZEROIZE_ON_LOAD = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    output logic         done,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic         rk_err
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_sched_ctrl supports only NR = 10 (AES-128)");
    end

    key_state_e   state_q, state_d;
    logic [127:0] store_q [0:AES_NR];
    logic [127:0] work_q, work_d;
    logic [127:0] step_key;
    rk_idx_t      rnd_q, rnd_d;
    logic [3:0]   avail_q, avail_d;
    logic         done_q, done_d;
    logic         rk_valid_q, rk_valid_d;
    logic         rk_err_q, rk_err_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic [127:0] rd_sel;
    logic         in_expand, last_step, accept;

    assign in_expand = (state_q == ST_EXPAND);
    assign last_step = in_expand && (rnd_q == rk_idx_t'(AES_NR));
    assign accept    = key_valid && key_ready;

    aes_key_step u_step (
        .prev_key (work_q),
        .rcon     (rcon_lut(rnd_q)),
        .next_key (step_key)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (key_valid) state_d = ST_EXPAND;
            ST_EXPAND: if (last_step) state_d = ST_READY;
            ST_READY:  if (key_valid) state_d = ST_EXPAND;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        key_ready  = (state_q == ST_IDLE) || (state_q == ST_READY);
        busy       = (state_q == ST_EXPAND);
        keys_valid = (state_q == ST_READY);
    end

    always_comb begin
        rnd_d   = rnd_q;
        avail_d = avail_q;
        work_d  = work_q;
        done_d  = 1'b0;
        if (accept) begin
            rnd_d   = 4'd1;
            avail_d = 4'd1;
            work_d  = key_in;
        end else if (in_expand) begin
            rnd_d   = rnd_q + 4'd1;
            avail_d = rnd_q + 4'd1;
            work_d  = step_key;
            done_d  = last_step;
        end
    end

    // Reads see the pre-edge store and avail, so a same-edge write is invisible.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i <= AES_NR; i++) begin
            if (rk_idx == rk_idx_t'(i)) rd_sel = store_q[i];
        end
        rk_valid_d = rk_req;
        rk_err_d   = 1'b0;
        rk_out_d   = rk_out_q;
        if (rk_req) begin
            if (rk_idx < avail_q) begin
                rk_out_d = rd_sel;
            end else begin
                rk_out_d = '0;
                rk_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q      <= '0;
            avail_q    <= '0;
            work_q     <= '0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_out_q   <= '0;
            for (int i = 0; i <= AES_NR; i++) store_q[i] <= '0;
        end else begin
            rnd_q      <= rnd_d;
            avail_q    <= avail_d;
            work_q     <= work_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            rk_err_q   <= rk_err_d;
            rk_out_q   <= rk_out_d;
            if (accept) begin
                store_q[0] <= key_in;
                if (ZEROIZE_ON_LOAD) begin
                    for (int i = 1; i <= AES_NR; i++) store_q[i] <= '0;
                end
            end else if (in_expand) begin
                for (int i = 1; i <= AES_NR; i++) begin
                    if (rnd_q == rk_idx_t'(i)) store_q[i] <= step_key;
                end
            end
        end
    end

    assign done     = done_q;
    assign rk_valid = rk_valid_q;
    assign rk_err   = rk_err_q;
    assign rk_out   = rk_out_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench: read responses checked by a scoreboard monitor, status
// outputs checked inline against hand-computed FIPS-197 values.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic         done;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic         rk_err;

    typedef struct {
        logic [127:0] out;
        logic         err;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(10), .ZEROIZE_ON_LOAD(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_out     (rk_out),
        .rk_err     (rk_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        rk_req = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] out, input logic err,
                      input string name);
        exp_t x;
        rk_req = 1'b1;
        rk_idx = idx;
        x.out  = out;
        x.err  = err;
        x.name = name;
        sb_q.push_back(x);
    endtask

    // Monitor: pops one expectation per response; rk_err must stay low otherwise.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rk_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rk_unexpected: got response idx-less %h, expected none", rk_out);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_out"}, rk_out, e.out);
                    chk({e.name, "_err"}, {127'b0, rk_err}, {127'b0, e.err});
                end
            end else begin
                chk("rk_err_idle", {127'b0, rk_err}, 128'd0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_req    = 1'b0;
        rk_idx    = '0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_key_ready",  {127'b0, key_ready},  128'd1);
        chk("rst_busy",       {127'b0, busy},       128'd0);
        chk("rst_keys_valid", {127'b0, keys_valid}, 128'd0);
        chk("rst_done",       {127'b0, done},       128'd0);
        chk("rst_rk_valid",   {127'b0, rk_valid},   128'd0);
        chk("rst_rk_out",     rk_out,               128'd0);

        // Key 1: accept at edge T, busy T+1..T+10, done/keys_valid at T+11.
        key_valid = 1'b1;
        key_in    = K1;
        step();
        key_valid = 1'b0;
        rd(4'd0, K1, 1'b0, "k1_early_idx0");
        chk("k1_busy_1", {127'b0, busy}, 128'd1);
        chk("k1_key_ready_1", {127'b0, key_ready}, 128'd0);
        step();
        rd(4'd5, 128'd0, 1'b1, "k1_early_idx5");
        for (int i = 2; i <= 10; i++) begin
            chk($sformatf("k1_busy_%0d", i), {127'b0, busy}, 128'd1);
            chk($sformatf("k1_done_%0d", i), {127'b0, done}, 128'd0);
            step();
        end
        chk("k1_busy_11",       {127'b0, busy},       128'd0);
        chk("k1_done_11",       {127'b0, done},       128'd1);
        chk("k1_keys_valid_11", {127'b0, keys_valid}, 128'd1);
        chk("k1_key_ready_11",  {127'b0, key_ready},  128'd1);
        rd(4'd1, K1_R1, 1'b0, "k1_idx1");
        step();
        chk("k1_done_12", {127'b0, done}, 128'd0);
        rd(4'd10, K1_R10, 1'b0, "k1_idx10");
        step();
        rd(4'd11, 128'd0, 1'b1, "k1_idx11");
        step();
        step();
        chk("idle_rk_valid", {127'b0, rk_valid}, 128'd0);

        // Key 2 with key_valid held through EXPAND: re-accepted at end of T+11.
        key_valid = 1'b1;
        key_in    = K2;
        step();
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("k2_key_ready_%0d", i), {127'b0, key_ready}, 128'd0);
            chk($sformatf("k2_busy_%0d", i),      {127'b0, busy},      128'd1);
            step();
        end
        chk("k2_done_11",       {127'b0, done},       128'd1);
        chk("k2_keys_valid_11", {127'b0, keys_valid}, 128'd1);
        chk("k2_key_ready_11",  {127'b0, key_ready},  128'd1);
        rd(4'd10, K2_R10, 1'b0, "k2_idx10_pre");
        step();
        key_valid = 1'b0;
        chk("k2_keys_valid_12", {127'b0, keys_valid}, 128'd0);
        chk("k2_busy_12",       {127'b0, busy},       128'd1);
        chk("k2_done_12",       {127'b0, done},       128'd0);
        for (int i = 13; i <= 21; i++) step();
        chk("k2_keys_valid_21", {127'b0, keys_valid}, 128'd0);
        step();
        chk("k2_keys_valid_22", {127'b0, keys_valid}, 128'd1);
        chk("k2_done_22",       {127'b0, done},       128'd1);
        rd(4'd10, K2_R10, 1'b0, "k2_idx10");
        step();

        // Accept in READY with a same-edge read: old entry 0, then the new key.
        key_valid = 1'b1;
        key_in    = K1;
        rd(4'd0, K2, 1'b0, "reload_old_idx0");
        step();
        key_valid = 1'b0;
        chk("reload_keys_valid", {127'b0, keys_valid}, 128'd0);
        chk("reload_busy",       {127'b0, busy},       128'd1);
        rd(4'd0, K1, 1'b0, "reload_new_idx0");
        step();
        step();
        step();
        step();

        // Abort by reset at T+5.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy",       {127'b0, busy},       128'd0);
        chk("abort_keys_valid", {127'b0, keys_valid}, 128'd0);
        chk("abort_key_ready",  {127'b0, key_ready},  128'd1);
        chk("abort_done",       {127'b0, done},       128'd0);
        rd(4'd0, 128'd0, 1'b1, "abort_idx0");
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("abort_no_done_%0d", i), {127'b0, done}, 128'd0);
        end
        chk("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
